// File: rtl/alu4_req_scheduler.sv
// alu4_req_scheduler: arbitrates two requesters onto one shared 4-bit ALU and returns tagged responses
module alu4_req_scheduler #(
  parameter bit FAIR      = 1'b1,
  parameter bit RST_GRANT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_op,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic       req0_chain,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_op,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic       req1_chain,
  output logic [3:0] alu_op,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  input  logic [3:0] alu_out,
  input  logic       alu_z,
  input  logic       alu_c,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [3:0] rsp_data,
  output logic       rsp_z,
  output logic       rsp_c,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
  state_t     state_q, state_d;
  logic [3:0] alu_op_q, alu_op_d, alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0] last_res0_q, last_res0_d, last_res1_q, last_res1_d;
  logic [3:0] rsp_data_q, rsp_data_d;
  logic       rsp_z_q, rsp_z_d, rsp_c_q, rsp_c_d, rsp_id_q, rsp_id_d;
  logic       rsp_valid_q, rsp_valid_d, busy_q, busy_d;
  logic       id_q, id_d, last_grant_q, last_grant_d;
  logic       idle, gnt0, gnt1;
  // Grant: a lone requester wins; a contest goes to the one not served last (or req0 when not fair)
  always_comb begin
    idle = state_q == IDLE;
    gnt1 = idle & req1_valid & (~req0_valid | (FAIR & ~last_grant_q));
    gnt0 = idle & req0_valid & ~gnt1;
  end
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  // Next state: latch operands on accept, capture ALU result after the single EXEC cycle
  always_comb begin
    state_d      = state_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    last_res0_d  = last_res0_q;
    last_res1_d  = last_res1_q;
    rsp_data_d   = rsp_data_q;
    rsp_z_d      = rsp_z_q;
    rsp_c_d      = rsp_c_q;
    rsp_id_d     = rsp_id_q;
    rsp_valid_d  = rsp_valid_q;
    busy_d       = busy_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: if (gnt0 | gnt1) begin
        alu_op_d     = gnt1 ? req1_op : req0_op;
        alu_a_d      = gnt1 ? (req1_chain ? last_res1_q : req1_a) : (req0_chain ? last_res0_q : req0_a);
        alu_b_d      = gnt1 ? req1_b : req0_b;
        id_d         = gnt1;
        last_grant_d = gnt1;
        busy_d       = 1'b1;
        state_d      = EXEC;
      end
      EXEC: begin
        rsp_data_d  = alu_out;
        rsp_z_d     = alu_z;
        rsp_c_d     = alu_c;
        rsp_id_d    = id_q;
        last_res0_d = id_q ? last_res0_q : alu_out;
        last_res1_d = id_q ? alu_out : last_res1_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
      default: begin
        rsp_valid_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end
  // State and registered outputs; reset aborts any op in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      last_res0_q  <= '0;
      last_res1_q  <= '0;
      rsp_data_q   <= '0;
      rsp_z_q      <= 1'b0;
      rsp_c_q      <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      id_q         <= 1'b0;
      last_grant_q <= RST_GRANT;
    end else begin
      state_q      <= state_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      last_res0_q  <= last_res0_d;
      last_res1_q  <= last_res1_d;
      rsp_data_q   <= rsp_data_d;
      rsp_z_q      <= rsp_z_d;
      rsp_c_q      <= rsp_c_d;
      rsp_id_q     <= rsp_id_d;
      rsp_valid_q  <= rsp_valid_d;
      busy_q       <= busy_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
    end
  end
  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_z     = rsp_z_q;
  assign rsp_c     = rsp_c_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_alu4_req_scheduler.sv
// tb_alu4_req_scheduler: directed checks of the scheduler against a behavioural shared ALU
module tb_alu4_req_scheduler;
  logic clk = 1'b0, rst = 1'b1;
  logic r0v, r1v, r0c, r1c, rsp_ready;
  logic [3:0] r0op, r0a, r0b, r1op, r1a, r1b;
  logic a_r0rdy, a_r1rdy, a_z, a_c, a_rv, a_id, a_rz, a_rc, a_busy;
  logic [3:0] a_op, a_a, a_b, a_out, a_data;
  logic b_r0rdy, b_r1rdy, b_z, b_c, b_rv, b_id, b_rz, b_rc, b_busy;
  logic [3:0] b_op, b_a, b_b, b_out, b_data;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  // ALU model: returns {carry, zero, result}
  function automatic logic [5:0] alu_f(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    logic [3:0] r;
    logic c;
    s = 5'd0;
    c = 1'b0;
    case (op)
      4'd0: r = a << 1;
      4'd1: r = a >> 1;
      4'd2: r = 4'($signed(a) >>> 1);
      4'd3: r = {a[2:0], a[3]};
      4'd4: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4]; end
      4'd5: begin s = {1'b0, a} + 5'd1; r = s[3:0]; c = s[4]; end
      4'd6: begin s = {1'b0, a} + {1'b0, ~b} + 5'd1; r = s[3:0]; c = s[4]; end
      4'd7: begin s = {1'b0, a} + 5'h0f; r = s[3:0]; c = s[4]; end
      4'd8: r = a & b;
      4'd9: r = a | b;
      4'd10: r = a ^ b;
      4'd11: r = ~a;
      4'd12: r = {3'd0, a == b};
      4'd13: r = {3'd0, a < b};
      4'd14: r = {3'd0, $signed(a) > $signed(b)};
      default: r = {3'd0, a > b};
    endcase
    return {c, r == 4'd0, r};
  endfunction
  assign {a_c, a_z, a_out} = alu_f(a_op, a_a, a_b);
  assign {b_c, b_z, b_out} = alu_f(b_op, b_a, b_b);
  alu4_req_scheduler #(.FAIR(1'b1), .RST_GRANT(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(r0v), .req0_ready(a_r0rdy), .req0_op(r0op), .req0_a(r0a), .req0_b(r0b), .req0_chain(r0c),
    .req1_valid(r1v), .req1_ready(a_r1rdy), .req1_op(r1op), .req1_a(r1a), .req1_b(r1b), .req1_chain(r1c),
    .alu_op(a_op), .alu_a(a_a), .alu_b(a_b), .alu_out(a_out), .alu_z(a_z), .alu_c(a_c),
    .rsp_valid(a_rv), .rsp_ready(rsp_ready), .rsp_id(a_id), .rsp_data(a_data), .rsp_z(a_rz), .rsp_c(a_rc),
    .busy(a_busy));
  alu4_req_scheduler #(.FAIR(1'b0), .RST_GRANT(1'b1)) dut_fixed (
    .clk(clk), .rst(rst),
    .req0_valid(r0v), .req0_ready(b_r0rdy), .req0_op(r0op), .req0_a(r0a), .req0_b(r0b), .req0_chain(r0c),
    .req1_valid(r1v), .req1_ready(b_r1rdy), .req1_op(r1op), .req1_a(r1a), .req1_b(r1b), .req1_chain(r1c),
    .alu_op(b_op), .alu_a(b_a), .alu_b(b_b), .alu_out(b_out), .alu_z(b_z), .alu_c(b_c),
    .rsp_valid(b_rv), .rsp_ready(rsp_ready), .rsp_id(b_id), .rsp_data(b_data), .rsp_z(b_rz), .rsp_c(b_rc),
    .busy(b_busy));
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_rsp(input string tag);
    int n = 0;
    while (a_rv !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    chk({tag, ".rsp_timeout"}, a_rv, 1'b1);
  endtask
  // One uncontested op through IDLE -> EXEC -> RESP -> IDLE with rsp_ready held high
  task automatic do_op(input string tag, input logic who, input logic [3:0] op, input logic [3:0] a,
                       input logic [3:0] b, input logic ch, input logic [3:0] ea, input logic [3:0] ed,
                       input logic ez, input logic ec);
    if (who) begin r1v = 1; r1op = op; r1a = a; r1b = b; r1c = ch; end
    else begin r0v = 1; r0op = op; r0a = a; r0b = b; r0c = ch; end
    #1;
    chk({tag, ".ready"}, who ? a_r1rdy : a_r0rdy, 1'b1);
    step();
    r0v = 0;
    r1v = 0;
    chk({tag, ".exec_busy"}, a_busy, 1'b1);
    chk({tag, ".exec_valid"}, a_rv, 1'b0);
    chk({tag, ".alu_a"}, a_a, ea);
    step();
    chk({tag, ".rsp_valid"}, a_rv, 1'b1);
    chk({tag, ".data"}, a_data, ed);
    chk({tag, ".z"}, a_rz, ez);
    chk({tag, ".c"}, a_rc, ec);
    chk({tag, ".id"}, a_id, who);
    step();
    chk({tag, ".idle_busy"}, a_busy, 1'b0);
    chk({tag, ".idle_valid"}, a_rv, 1'b0);
  endtask
  initial begin
    r0v = 0; r1v = 0; r0c = 0; r1c = 0; rsp_ready = 1;
    r0op = 0; r0a = 0; r0b = 0; r1op = 0; r1a = 0; r1b = 0;
    step();
    step();
    chk("rst.busy", a_busy, 1'b0);
    chk("rst.rsp_valid", a_rv, 1'b0);
    chk("rst.alu_op", a_op, 4'd0);
    chk("rst.rsp_data", a_data, 4'd0);
    rst = 0;
    step();
    do_op("t1_add", 1'b0, 4'd4, 4'd5, 4'd3, 1'b0, 4'd5, 4'd8, 1'b0, 1'b0);
    do_op("t3_add", 1'b1, 4'd4, 4'd9, 4'd9, 1'b0, 4'd9, 4'd2, 1'b0, 1'b1);
    do_op("t3_chain", 1'b1, 4'd5, 4'hf, 4'd0, 1'b1, 4'd2, 4'd3, 1'b0, 1'b0);
    r0v = 1; r0op = 4'd4; r0a = 4'd1; r0b = 4'd1; r0c = 0;
    r1v = 1; r1op = 4'd4; r1a = 4'd1; r1b = 4'd1; r1c = 0;
    #1;
    chk("t2.ready0", a_r0rdy, 1'b1);
    chk("t2.ready1", a_r1rdy, 1'b0);
    chk("t2.fixed_ready0", b_r0rdy, 1'b1);
    for (int k = 0; k < 4; k++) begin
      wait_rsp("t2");
      chk($sformatf("t2.rr_id%0d", k), a_id, k[0]);
      chk($sformatf("t2.fixed_id%0d", k), b_id, 1'b0);
      chk($sformatf("t2.fixed_valid%0d", k), b_rv, 1'b1);
      step();
    end
    r0v = 0;
    r1v = 0;
    rsp_ready = 0;
    r0v = 1; r0op = 4'd8; r0a = 4'hc; r0b = 4'ha; r0c = 0;
    #1;
    chk("t4.ready0", a_r0rdy, 1'b1);
    step();
    r0v = 0;
    step();
    chk("t4.data", a_data, 4'd8);
    r0v = 1;
    r1v = 1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t4.hold_valid", a_rv, 1'b1);
      chk("t4.hold_data", a_data, 4'd8);
      chk("t4.hold_id", a_id, 1'b0);
      chk("t4.hold_ready0", a_r0rdy, 1'b0);
      chk("t4.hold_ready1", a_r1rdy, 1'b0);
      chk("t4.hold_busy", a_busy, 1'b1);
    end
    r0v = 0;
    r1v = 0;
    rsp_ready = 1;
    step();
    chk("t4.release_busy", a_busy, 1'b0);
    chk("t4.release_valid", a_rv, 1'b0);
    r1v = 1; r1op = 4'd4; r1a = 4'd1; r1b = 4'd1; r1c = 0;
    step();
    r1v = 0;
    chk("t5.exec_busy", a_busy, 1'b1);
    rst = 1;
    #1;
    chk("t5.rst_busy", a_busy, 1'b0);
    chk("t5.rst_valid", a_rv, 1'b0);
    chk("t5.rst_alu_op", a_op, 4'd0);
    chk("t5.rst_alu_a", a_a, 4'd0);
    chk("t5.rst_alu_b", a_b, 4'd0);
    chk("t5.rst_data", a_data, 4'd0);
    step();
    step();
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t5.no_rsp", a_rv, 1'b0);
    end
    r0v = 1;
    r1v = 1;
    #1;
    chk("t5.rst_grant0", a_r0rdy, 1'b1);
    chk("t5.rst_grant1", a_r1rdy, 1'b0);
    r0v = 0;
    r1v = 0;
    #1;
    do_op("t5_chain", 1'b0, 4'd5, 4'd7, 4'd0, 1'b1, 4'd0, 4'd1, 1'b0, 1'b0);
    do_op("t6_sub", 1'b0, 4'd6, 4'd3, 4'd3, 1'b0, 4'd3, 4'd0, 1'b1, 1'b1);
    do_op("t6_sgt", 1'b0, 4'd14, 4'd7, 4'd8, 1'b0, 4'd7, 4'd1, 1'b0, 1'b0);
    do_op("own_hist", 1'b1, 4'd5, 4'd9, 4'd0, 1'b1, 4'd0, 4'd1, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
